// File: rtl/fb_pkg.sv
// ============================================================================
// Module : fb_pkg
// Brief  : Shared constants, pixel type and writer state encoding for the
//          frame-buffer column writer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fb_pkg;

  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 180;
  localparam int PIXEL_WIDTH   = 16;

  localparam int COL_W  = 9;
  localparam int ROW_W  = 8;
  localparam int ADDR_W = 16;

  typedef logic [PIXEL_WIDTH-1:0] rgb565_t;

  localparam rgb565_t CEIL_COLOR  = 16'h18E3;
  localparam rgb565_t FLOOR_COLOR = 16'h4208;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    DRAW      = 2'd2,
    WAIT_SWAP = 2'd3
  } writer_state_e;

  // Halve each RGB565 channel independently so no bit leaks between fields.
  function automatic rgb565_t rgb565_half(input rgb565_t c);
    return {1'b0, c[15:12], 1'b0, c[10:6], 1'b0, c[4:1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fb_column_writer_if.sv
// ============================================================================
// Module : fb_column_writer_if
// Brief  : Column-result input channel, swap handshake and frame-buffer
//          write port of the column writer, bundled with modports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fb_column_writer_if;
  import fb_pkg::*;

  logic               col_valid_in;
  logic               col_ready_out;
  logic [COL_W-1:0]   col_index_in;
  logic [8:0]         line_height_in;
  rgb565_t            wall_color_in;
  logic               side_in;
  logic               swap_done_in;

  logic               ray_valid_out;
  logic [ADDR_W-1:0]  ray_address_out;
  rgb565_t            ray_pixel_out;
  logic               ray_last_pixel_out;
  logic               waiting_swap_out;

  modport slave (
    input  col_valid_in, col_index_in, line_height_in, wall_color_in,
           side_in, swap_done_in,
    output col_ready_out, ray_valid_out, ray_address_out, ray_pixel_out,
           ray_last_pixel_out, waiting_swap_out
  );

  modport master (
    output col_valid_in, col_index_in, line_height_in, wall_color_in,
           side_in, swap_done_in,
    input  col_ready_out, ray_valid_out, ray_address_out, ray_pixel_out,
           ray_last_pixel_out, waiting_swap_out
  );

endinterface

`default_nettype wire

// File: rtl/fb_column_writer_wall_span_calc.sv
// ============================================================================
// Module : wall_span_calc
// Brief  : Clamps the wall height to the screen and registers the vertically
//          centred wall span (first and last wall row) on load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wall_span_calc
  import fb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [8:0]       line_height_i,
  output logic [ROW_W-1:0] draw_start_o,
  output logic [ROW_W-1:0] draw_end_o
);

  logic [ROW_W-1:0] h_d;
  logic [ROW_W-1:0] start_d;
  logic [ROW_W-1:0] end_d;
  logic [ROW_W-1:0] start_q;
  logic [ROW_W-1:0] end_q;

  // With h=0 the end lands one row above the start, so no row is wall.
  always_comb begin
    h_d     = (line_height_i > 9'(SCREEN_HEIGHT)) ? ROW_W'(SCREEN_HEIGHT)
                                                  : line_height_i[ROW_W-1:0];
    start_d = (ROW_W'(SCREEN_HEIGHT) - h_d) >> 1;
    end_d   = start_d + h_d - 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_q <= '0;
      end_q   <= '0;
    end else if (load_i) begin
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

  assign draw_start_o = start_q;
  assign draw_end_o   = end_q;

endmodule

`default_nettype wire

// File: rtl/fb_column_writer.sv
// ============================================================================
// Module : fb_column_writer
// Brief  : Expands per-column ray results into one RGB565 frame-buffer write
//          per row, flags the frame's final write and holds off until swap.
//          Optional build macro FB_WRITER_SIDE_SHADE_EN halves Y-side walls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_column_writer
  import fb_pkg::*;
(
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  fb_column_writer_if.slave   bus
);

  writer_state_e     state_q;
  writer_state_e     state_d;

  logic [COL_W-1:0]  col_q;
  rgb565_t           wall_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_q;
  rgb565_t           pix_q;
  logic              valid_q;
  logic              last_q;
  logic [COL_W-1:0]  count_q;

  logic              transfer;
  logic              col_on_screen;
  logic              last_row;
  logic              frame_last;
  rgb565_t           wall_in;
  logic [ROW_W-1:0]  draw_start;
  logic [ROW_W-1:0]  draw_end;

  function automatic rgb565_t pick_pixel(
    input logic [ROW_W-1:0] row,
    input logic [ROW_W-1:0] s,
    input logic [ROW_W-1:0] e,
    input rgb565_t          wall
  );
    if (row < s)       return CEIL_COLOR;
    else if (row <= e) return wall;
    else               return FLOOR_COLOR;
  endfunction

  assign transfer      = bus.col_valid_in && (state_q == IDLE);
  assign col_on_screen = col_q < COL_W'(SCREEN_WIDTH);
  assign last_row      = row_q == ROW_W'(SCREEN_HEIGHT - 1);
  assign frame_last    = count_q == COL_W'(SCREEN_WIDTH - 1);

`ifdef FB_WRITER_SIDE_SHADE_EN
  assign wall_in = bus.side_in ? rgb565_half(bus.wall_color_in) : bus.wall_color_in;
`else
  assign wall_in = bus.wall_color_in;
`endif

  wall_span_calc u_span (
    .clk_i         (pixel_clk_in),
    .rst_i         (rst_in),
    .load_i        (transfer),
    .line_height_i (bus.line_height_in),
    .draw_start_o  (draw_start),
    .draw_end_o    (draw_end)
  );

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (transfer) state_d = SETUP;
      SETUP:     state_d = col_on_screen ? DRAW : IDLE;
      DRAW:      if (last_row) state_d = frame_last ? WAIT_SWAP : IDLE;
      WAIT_SWAP: if (bus.swap_done_in) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.col_ready_out    = (state_q == IDLE);
    bus.waiting_swap_out = (state_q == WAIT_SWAP);
  end

  assign bus.ray_valid_out      = valid_q;
  assign bus.ray_address_out    = addr_q;
  assign bus.ray_pixel_out      = pix_q;
  assign bus.ray_last_pixel_out = last_q;

  // Write outputs are pre-computed one row ahead so each DRAW cycle presents
  // the row held in row_q; the address steps by one screen line per row.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      col_q   <= '0;
      wall_q  <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (transfer) begin
        col_q  <= bus.col_index_in;
        wall_q <= wall_in;
      end
      case (state_q)
        SETUP: begin
          if (col_on_screen) begin
            row_q   <= '0;
            addr_q  <= ADDR_W'(col_q);
            pix_q   <= pick_pixel('0, draw_start, draw_end, wall_q);
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        DRAW: begin
          if (!last_row) begin
            row_q   <= row_q + 8'd1;
            addr_q  <= addr_q + ADDR_W'(SCREEN_WIDTH);
            pix_q   <= pick_pixel(row_q + 8'd1, draw_start, draw_end, wall_q);
            last_q  <= frame_last && (row_q == ROW_W'(SCREEN_HEIGHT - 2));
          end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            count_q <= frame_last ? '0 : count_q + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fb_column_writer.sv
// ============================================================================
// Module : tb_fb_column_writer
// Brief  : Directed self-checking bench for fb_column_writer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fb_column_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_column_writer_if bus ();

  fb_column_writer dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .bus          (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int total_lasts  = 0;
  logic [15:0] pix_row90;
  logic [15:0] addr_row179;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int row, input int h, input logic [15:0] wc);
    int hc;
    int s;
    int e;
    hc = (h > 180) ? 180 : h;
    s  = (180 - hc) / 2;
    e  = s + hc - 1;
    if (row < s)       return 16'h18E3;
    else if (row <= e) return wc;
    else               return 16'h4208;
  endfunction

  task automatic run_col(input int col, input int h, input logic [15:0] wc,
                         input logic side, input bit exp_last);
    int waited   = 0;
    int writes   = 0;
    int bad      = 0;
    int lasts    = 0;
    int last_row = -1;
    logic [15:0] wexp;
    wexp = wc;
`ifdef FB_WRITER_SIDE_SHADE_EN
    begin
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
      r = wc[15:11];
      g = wc[10:5];
      b = wc[4:0];
      if (side) wexp = {r >> 1, g >> 1, b >> 1};
    end
`endif
    @(negedge clk);
    while (!bus.col_ready_out && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before_col", 32'(bus.col_ready_out), 32'd1);
    bus.col_valid_in   = 1'b1;
    bus.col_index_in   = 9'(col);
    bus.line_height_in = 9'(h);
    bus.wall_color_in  = wc;
    bus.side_in        = side;
    @(posedge clk);
    #1;
    bus.col_valid_in   = 1'b0;
    bus.col_index_in   = 9'd5;
    bus.line_height_in = 9'd1;
    bus.wall_color_in  = 16'h0000;
    bus.side_in        = ~side;
    if (col >= 320) begin
      repeat (4) begin
        @(negedge clk);
        if (bus.ray_valid_out) writes++;
      end
      chk("offscreen_writes", 32'(writes), 32'd0);
      chk("offscreen_ready", 32'(bus.col_ready_out), 32'd1);
      return;
    end
    @(negedge clk);
    chk("setup_no_write", 32'(bus.ray_valid_out), 32'd0);
    for (int row = 0; row < 180; row++) begin
      @(negedge clk);
      if (bus.ray_valid_out) writes++;
      if (bus.ray_address_out !== 16'(row * 320 + col) ||
          bus.ray_pixel_out !== exp_pix(row, h, wexp)) bad++;
      if (bus.ray_last_pixel_out) begin
        lasts++;
        last_row = row;
      end
      if (row == 0)   chk("first_write_t+2", 32'(bus.ray_valid_out), 32'd1);
      if (row == 90)  pix_row90   = bus.ray_pixel_out;
      if (row == 179) addr_row179 = bus.ray_address_out;
    end
    @(negedge clk);
    chk("write_stops", 32'(bus.ray_valid_out), 32'd0);
    chk("write_count", 32'(writes), 32'd180);
    chk("pixel_errors", 32'(bad), 32'd0);
    chk("last_flags", 32'(lasts), exp_last ? 32'd1 : 32'd0);
    if (exp_last) chk("last_row", 32'(last_row), 32'd179);
    total_lasts += lasts;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.col_valid_in   = 1'b0;
    bus.col_index_in   = '0;
    bus.line_height_in = '0;
    bus.wall_color_in  = '0;
    bus.side_in        = 1'b0;
    bus.swap_done_in   = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready",   32'(bus.col_ready_out),      32'd1);
    chk("rst_valid",   32'(bus.ray_valid_out),      32'd0);
    chk("rst_addr",    32'(bus.ray_address_out),    32'd0);
    chk("rst_pixel",   32'(bus.ray_pixel_out),      32'd0);
    chk("rst_last",    32'(bus.ray_last_pixel_out), 32'd0);
    chk("rst_waiting", 32'(bus.waiting_swap_out),   32'd0);

    // Basic column: rows 60..119 are wall.
    run_col(0, 60, 16'hF800, 1'b0, 1'b0);
    chk("h60_row90", 32'(pix_row90), 32'hF800);
    chk("h60_addr179", 32'(addr_row179), 32'd57280);

    // Height boundaries.
    run_col(1, 0, 16'hF800, 1'b0, 1'b0);
    chk("h0_row90", 32'(pix_row90), 32'h4208);
    run_col(2, 400, 16'h001F, 1'b0, 1'b0);
    chk("h400_row90", 32'(pix_row90), 32'h001F);

    // Y-side shading.
    run_col(4, 180, 16'hFFFF, 1'b1, 1'b0);
`ifdef FB_WRITER_SIDE_SHADE_EN
    chk("shade_row90", 32'(pix_row90), 32'h7BEF);
`else
    chk("shade_row90", 32'(pix_row90), 32'hFFFF);
`endif

    // Reset mid-DRAW on row 50.
    @(negedge clk);
    bus.col_valid_in   = 1'b1;
    bus.col_index_in   = 9'd3;
    bus.line_height_in = 9'd100;
    bus.wall_color_in  = 16'h07E0;
    @(posedge clk);
    #1 bus.col_valid_in = 1'b0;
    repeat (52) @(negedge clk);
    chk("row50_addr", 32'(bus.ray_address_out), 32'd16003);
    chk("row50_valid", 32'(bus.ray_valid_out), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.ray_valid_out),   32'd0);
    chk("midrst_ready", 32'(bus.col_ready_out),   32'd1);
    chk("midrst_addr",  32'(bus.ray_address_out), 32'd0);
    chk("midrst_pixel", 32'(bus.ray_pixel_out),   32'd0);

    // Off-screen column and stray swap pulse in IDLE.
    run_col(320, 50, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    bus.swap_done_in = 1'b1;
    @(posedge clk);
    #1 bus.swap_done_in = 1'b0;
    @(negedge clk);
    chk("idle_swap_ready",   32'(bus.col_ready_out),    32'd1);
    chk("idle_swap_waiting", 32'(bus.waiting_swap_out), 32'd0);

    // Full frame of 320 columns in permuted order; counter restarted at 0.
    for (int i = 0; i < 320; i++) begin
      run_col((i * 7) % 320, i % 200, 16'(i * 1237 + 3), 1'(i & 1), i == 319);
    end
    chk("frame_total_lasts", 32'(total_lasts), 32'd1);
    chk("wait_swap_flag", 32'(bus.waiting_swap_out), 32'd1);
    begin
      int ready_seen = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.col_ready_out) ready_seen++;
      end
      chk("wait_swap_ready_low", 32'(ready_seen), 32'd0);
    end

    // Swap and column offered together: accepted only on the following cycle.
    bus.swap_done_in   = 1'b1;
    bus.col_valid_in   = 1'b1;
    bus.col_index_in   = 9'd10;
    bus.line_height_in = 9'd60;
    bus.wall_color_in  = 16'h07E0;
    bus.side_in        = 1'b0;
    @(posedge clk);
    #1 bus.swap_done_in = 1'b0;
    @(negedge clk);
    chk("post_swap_ready",   32'(bus.col_ready_out),    32'd1);
    chk("post_swap_waiting", 32'(bus.waiting_swap_out), 32'd0);
    @(posedge clk);
    #1 bus.col_valid_in = 1'b0;
    @(negedge clk);
    chk("post_swap_accepted", 32'(bus.col_ready_out), 32'd0);
    @(negedge clk);
    chk("post_swap_write",  32'(bus.ray_valid_out),   32'd1);
    chk("post_swap_addr",   32'(bus.ray_address_out), 32'd10);
    chk("post_swap_pixel",  32'(bus.ray_pixel_out),   32'h18E3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
